pc_ir_unit: RTL and testbench
=============================

# pc_ir_unit

Program-counter and instruction-register stage of the multi-cycle CPU, sitting directly upstream of the control unit. It holds PC and IR and selects the next PC from the controller's `PCSrc`. It decodes the latched instruction into the `Opcode` field consumed by the control unit and the register/immediate fields consumed by the datapath. It also keeps a retired-instruction counter and a sticky misaligned-target flag.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- `CLK`  in  1  system clock; all state changes on rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `PCWre`  in  1  PC write enable from control unit (one cycle per instruction, final state).
- `PCSrc`  in  2  next-PC select: 00 PC+4, 01 branch, 10 register (jr), 11 jump.
- `IRWre`  in  1  IR load enable (IF state).
- `InsMemRW`  in  1  instruction memory read enable; IR loads only when `IRWre` & `InsMemRW`.
- `InsData`  in  32  instruction word from instruction memory at `InsAddr`.
- `ExtImm`  in  32  extended 16-bit immediate from the extender.
- `RegData1`  in  32  rs register value, used as the jr target.
- `InsAddr`  out  32  instruction memory address; equals PC.
- `PC`, `PC4`  out  32  current PC, and PC+4 (mod 2^32).
- `Opcode`  out  6  IR[31:26], to the control unit.
- `rs`, `rt`, `rd`  out  5 each  IR[25:21], IR[20:16], IR[15:11].
- `sa`  out  5  IR[10:6].
- `immediate`  out  16  IR[15:0].
- `InsCount`  out  32  number of PC updates since reset.
- `AddrErr`  out  1  sticky flag: a misaligned next-PC was produced.

## Operation
- Registers: PC, IR, InsCount, AddrErr.
- All field outputs are combinational slices of IR.
- `InsAddr`/`PC` are the PC register. `PC4` = PC + 32'd4 with wrap-around.
- Next-PC candidates, from the current PC register:
  - 00: PC4.
  - 01: PC4 + (ExtImm << 2), 32-bit wrap. ExtImm is used as supplied; the signedness decision belongs to the extender.
  - 10: RegData1.
  - 11: {PC4[31:28], IR[25:0], 2'b00}.
- Alignment: if the selected target has bits [1:0] ≠ 0 (possible only for 10), the PC loads target with [1:0] forced to 00, and AddrErr sets.
- AddrErr remains set until reset; it does not block execution.
- PCWre=1: PC ← target and InsCount ← InsCount+1 (wraps at 2^32). PCWre=0: PC and InsCount hold.
- IRWre & InsMemRW: IR ← InsData. Otherwise IR holds, including IRWre=1 with InsMemRW=0.
- Simultaneous PCWre and IR load in one cycle:
  - IR captures `InsData` for the old PC.
  - The target uses the old IR (jump field) and the old PC.
- `PCSrc` is ignored when PCWre=0. An X on `PCSrc` with PCWre=0 must not corrupt the PC.

## Timing
- Reset (Reset=0 at a rising edge) sets:
  - PC=RESET_PC, IR=32'h0000_0000 (Opcode=000000, all fields 0).
  - InsCount=0, AddrErr=0.
  - Outputs reflect these in the cycle after the edge.
- Reset dominates PCWre/IRWre in the same cycle. Reset mid-instruction discards any pending update.
- Fetch latency: `InsData` presented in cycle N with IRWre=InsMemRW=1 appears on `Opcode`/fields after edge N+1 (one register stage).
- PC update latency: one edge. The new `InsAddr` is valid the cycle after the edge where PCWre=1.
- No combinational path from `InsData` to any output.
- Combinational paths to next-PC only: `RegData1`, `ExtImm`, `PCSrc`.

## Test plan
- Reset: hold Reset=0 for 2 edges with PCWre=IRWre=1 -> PC=0, Opcode=0, InsCount=0, AddrErr=0. Release -> all unchanged until an enable is asserted.
- Sequential fetch: InsData=32'h0221_8020, IRWre=InsMemRW=1, then PCSrc=00 with PCWre=1 -> rs=17, rt=1, rd=16, PC=4, InsCount=1. Repeat 3× -> PC=16, InsCount=4.
- Branch back: PC=32'h10, ExtImm=32'hFFFF_FFFD, PCSrc=01, PCWre=1 -> PC=32'h08. PC=32'hFFFF_FFFC, ExtImm=0 -> PC=0 (wrap).
- Jump: PC=32'h3000_0010, IR=32'h0800_0040, PCSrc=11 -> PC=32'h3000_0100.
- jr misaligned: RegData1=32'h0000_0023, PCSrc=10 -> PC=32'h20, AddrErr=1. A later aligned jr leaves AddrErr=1.
- Hold/gating:
  - IRWre=1, InsMemRW=0 -> IR unchanged.
  - PCWre=0 with PCSrc=X -> PC unchanged.
  - Reset=0 asserted mid-sequence together with PCWre=1 -> PC=RESET_PC.

Source files
------------

// File: rtl/pc_ir_unit.sv
// pc_ir_unit: program-counter / instruction-register stage of the multi-cycle CPU.
// Holds PC and IR, selects the next PC from pc_src_i, decodes the latched IR
// into opcode/register/immediate fields, counts PC updates and keeps a sticky
// misaligned-target flag.
//
// Ports:
//   clk_i          system clock, all state changes on the rising edge
//   rst_ni         synchronous active-low reset
//   pc_wre_i       PC write enable (one cycle per instruction)
//   pc_src_i       next-PC select: 00 PC+4, 01 branch, 10 register (jr), 11 jump
//   ir_wre_i       IR load enable
//   ins_mem_rw_i   instruction memory read enable; IR loads on ir_wre_i & ins_mem_rw_i
//   ins_data_i     instruction word from memory at ins_addr_o
//   ext_imm_i      extended immediate (signedness decided by the extender)
//   reg_data1_i    rs value, the jr target
//   ins_addr_o     instruction memory address (= PC)
//   pc_o, pc4_o    current PC and PC+4
//   opcode_o, rs_o, rt_o, rd_o, sa_o, immediate_o   slices of the IR
//   ins_count_o    number of PC updates since reset
//   addr_err_o     sticky: a misaligned next-PC was produced
module pc_ir_unit #(
    parameter logic [31:0] ResetPc = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pc_wre_i,
    input  logic [1:0]  pc_src_i,
    input  logic        ir_wre_i,
    input  logic        ins_mem_rw_i,
    input  logic [31:0] ins_data_i,
    input  logic [31:0] ext_imm_i,
    input  logic [31:0] reg_data1_i,
    output logic [31:0] ins_addr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [5:0]  opcode_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  sa_o,
    output logic [15:0] immediate_o,
    output logic [31:0] ins_count_o,
    output logic        addr_err_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ins_count_q, ins_count_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] pc4;
    logic [31:0] target;

    assign pc4 = pc_q + 32'd4;

    // Target is built from the current (old) PC and IR, so a same-cycle IR load
    // never affects the jump field used here.
    always_comb begin
        target = pc4;
        unique case (pc_src_i)
            2'b00:   target = pc4;
            2'b01:   target = pc4 + {ext_imm_i[29:0], 2'b00};
            2'b10:   target = reg_data1_i;
            2'b11:   target = {pc4[31:28], ir_q[25:0], 2'b00};
            default: target = pc4;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        ins_count_d = ins_count_q;
        addr_err_d  = addr_err_q;
        ir_d        = ir_q;
        // pc_src_i only matters when the PC is written, so an unknown select
        // while idle cannot reach the PC register.
        if (pc_wre_i) begin
            pc_d        = {target[31:2], 2'b00};
            ins_count_d = ins_count_q + 32'd1;
            if (target[1:0] != 2'b00) begin
                addr_err_d = 1'b1;
            end
        end
        if (ir_wre_i && ins_mem_rw_i) begin
            ir_d = ins_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q        <= ResetPc;
            ir_q        <= 32'h0000_0000;
            ins_count_q <= 32'h0000_0000;
            addr_err_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ins_count_q <= ins_count_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign ins_addr_o  = pc_q;
    assign pc_o        = pc_q;
    assign pc4_o       = pc4;
    assign opcode_o    = ir_q[31:26];
    assign rs_o        = ir_q[25:21];
    assign rt_o        = ir_q[20:16];
    assign rd_o        = ir_q[15:11];
    assign sa_o        = ir_q[10:6];
    assign immediate_o = ir_q[15:0];
    assign ins_count_o = ins_count_q;
    assign addr_err_o  = addr_err_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed, table-driven bench for pc_ir_unit. Each record is one clock:
// inputs are applied, one rising edge passes, outputs are compared 1 ns later.
module tb_pc_ir_unit;

    logic        clk;
    logic        rst_n;
    logic        pc_wre;
    logic [1:0]  pc_src;
    logic        ir_wre;
    logic        ins_mem_rw;
    logic [31:0] ins_data;
    logic [31:0] ext_imm;
    logic [31:0] reg_data1;
    logic [31:0] ins_addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] immediate;
    logic [31:0] ins_count;
    logic        addr_err;

    pc_ir_unit #(
        .ResetPc(32'h0000_0000)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .pc_wre_i    (pc_wre),
        .pc_src_i    (pc_src),
        .ir_wre_i    (ir_wre),
        .ins_mem_rw_i(ins_mem_rw),
        .ins_data_i  (ins_data),
        .ext_imm_i   (ext_imm),
        .reg_data1_i (reg_data1),
        .ins_addr_o  (ins_addr),
        .pc_o        (pc),
        .pc4_o       (pc4),
        .opcode_o    (opcode),
        .rs_o        (rs),
        .rt_o        (rt),
        .rd_o        (rd),
        .sa_o        (sa),
        .immediate_o (immediate),
        .ins_count_o (ins_count),
        .addr_err_o  (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        pc_wre;
        logic [1:0]  pc_src;
        logic        ir_wre;
        logic        ins_mem_rw;
        logic [31:0] ins_data;
        logic [31:0] ext_imm;
        logic [31:0] reg_data1;
        logic [31:0] exp_pc;
        logic [31:0] exp_ir;
        logic [31:0] exp_count;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic push(input logic r, input logic pw, input logic [1:0] ps, input logic iw,
                        input logic mr, input logic [31:0] d, input logic [31:0] ei,
                        input logic [31:0] rd1, input logic [31:0] epc, input logic [31:0] eir,
                        input logic [31:0] ecnt, input logic eerr);
        vec_t v;
        v.rst_n = r;       v.pc_wre = pw;      v.pc_src = ps;    v.ir_wre = iw;
        v.ins_mem_rw = mr; v.ins_data = d;     v.ext_imm = ei;   v.reg_data1 = rd1;
        v.exp_pc = epc;    v.exp_ir = eir;     v.exp_count = ecnt; v.exp_err = eerr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL vec %0d %s: got 32'h%08h, expected 32'h%08h", idx, name, act, exp);
        end
    endtask

    task automatic check_state(input int idx, input logic [31:0] epc, input logic [31:0] eir,
                               input logic [31:0] ecnt, input logic eerr);
        logic [31:0] epc4;
        epc4 = epc + 32'd4;
        n_vec++;
        chk("pc", idx, pc, epc);
        chk("ins_addr", idx, ins_addr, epc);
        chk("pc4", idx, pc4, epc4);
        chk("opcode", idx, {26'd0, opcode}, {26'd0, eir[31:26]});
        chk("rs", idx, {27'd0, rs}, {27'd0, eir[25:21]});
        chk("rt", idx, {27'd0, rt}, {27'd0, eir[20:16]});
        chk("rd", idx, {27'd0, rd}, {27'd0, eir[15:11]});
        chk("sa", idx, {27'd0, sa}, {27'd0, eir[10:6]});
        chk("immediate", idx, {16'd0, immediate}, {16'd0, eir[15:0]});
        chk("ins_count", idx, ins_count, ecnt);
        chk("addr_err", idx, {31'd0, addr_err}, {31'd0, eerr});
    endtask

    localparam logic [31:0] IrA = 32'h0221_8020;  // rs=17 rt=1 rd=16
    localparam logic [31:0] IrJ = 32'h0800_0040;  // j, target field 0x40

    initial begin
        // rst pw  src    iw   mr   data          ext_imm       reg_data1     exp_pc        exp_ir exp_cnt err
        push(0, 1, 2'b00, 1, 1, IrA,          32'h0,        32'h0,        32'h0,        32'h0, 0,  0);
        push(0, 1, 2'b00, 1, 1, IrA,          32'h0,        32'h0,        32'h0,        32'h0, 0,  0);
        push(1, 0, 2'b00, 0, 0, 32'hFFFF_FFFF, 32'h0,       32'h0,        32'h0,        32'h0, 0,  0);
        push(1, 0, 2'b00, 1, 1, IrA,          32'h0,        32'h0,        32'h0,        IrA,   0,  0);
        push(1, 1, 2'b00, 0, 0, 32'h0,        32'h0,        32'h0,        32'h4,        IrA,   1,  0);
        push(1, 1, 2'b00, 0, 0, 32'h0,        32'h0,        32'h0,        32'h8,        IrA,   2,  0);
        push(1, 1, 2'b00, 0, 0, 32'h0,        32'h0,        32'h0,        32'hC,        IrA,   3,  0);
        push(1, 1, 2'b00, 0, 0, 32'h0,        32'h0,        32'h0,        32'h10,       IrA,   4,  0);
        // branch back: 0x14 + (-3 << 2) = 0x08
        push(1, 1, 2'b01, 0, 0, 32'h0,        32'hFFFF_FFFD, 32'h0,       32'h8,        IrA,   5,  0);
        push(1, 1, 2'b10, 0, 0, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'hFFFF_FFFC, IrA,  6,  0);
        // branch from the top of memory wraps to 0
        push(1, 1, 2'b01, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        IrA,   7,  0);
        push(1, 0, 2'b00, 1, 1, IrJ,          32'h0,        32'h0,        32'h0,        IrJ,   7,  0);
        push(1, 1, 2'b10, 0, 0, 32'h0,        32'h0,        32'h3000_0010, 32'h3000_0010, IrJ, 8,  0);
        push(1, 1, 2'b11, 0, 0, 32'h0,        32'h0,        32'h0,        32'h3000_0100, IrJ,  9,  0);
        // misaligned jr: low bits dropped, sticky flag set
        push(1, 1, 2'b10, 0, 0, 32'h0,        32'h0,        32'h23,       32'h20,       IrJ,   10, 1);
        push(1, 1, 2'b10, 0, 0, 32'h0,        32'h0,        32'h40,       32'h40,       IrJ,   11, 1);
        // IRWre without InsMemRW: IR holds
        push(1, 0, 2'b00, 1, 0, 32'hFFFF_FFFF, 32'h0,       32'h0,        32'h40,       IrJ,   11, 1);
        // PCWre=0 with unknown select: PC holds
        push(1, 0, 2'bxx, 0, 0, 32'h0,        32'h0,        32'h0,        32'h40,       IrJ,   11, 1);
        // simultaneous PC write and IR load: jump uses the old IR (0x44 -> 0x100)
        push(1, 1, 2'b11, 1, 1, IrA,          32'h0,        32'h0,        32'h100,      IrA,   12, 1);
        // reset dominates a pending PC write
        push(0, 1, 2'b00, 1, 1, IrJ,          32'h0,        32'h0,        32'h0,        32'h0, 0,  0);
        push(1, 1, 2'b00, 0, 0, 32'h0,        32'h0,        32'h0,        32'h4,        32'h0, 1,  0);

        rst_n = 1'b0; pc_wre = 1'b0; pc_src = 2'b00; ir_wre = 1'b0; ins_mem_rw = 1'b0;
        ins_data = 32'h0; ext_imm = 32'h0; reg_data1 = 32'h0;
        @(negedge clk);

        foreach (vecs[i]) begin
            rst_n      = vecs[i].rst_n;
            pc_wre     = vecs[i].pc_wre;
            pc_src     = vecs[i].pc_src;
            ir_wre     = vecs[i].ir_wre;
            ins_mem_rw = vecs[i].ins_mem_rw;
            ins_data   = vecs[i].ins_data;
            ext_imm    = vecs[i].ext_imm;
            reg_data1  = vecs[i].reg_data1;
            @(posedge clk);
            #1;
            check_state(i, vecs[i].exp_pc, vecs[i].exp_ir, vecs[i].exp_count, vecs[i].exp_err);
            @(negedge clk);
        end

        // Fetch latency: new InsData is invisible until the edge that loads it.
        ir_wre = 1'b1; ins_mem_rw = 1'b1; pc_wre = 1'b0; ins_data = IrJ;
        reg_data1 = 32'hDEAD_BEE0;
        #1;
        check_state(100, 32'h4, 32'h0, 32'd1, 1'b0);
        @(posedge clk);
        #1;
        check_state(101, 32'h4, IrJ, 32'd1, 1'b0);

        // After release, outputs stay put while no enable is asserted.
        @(negedge clk);
        ir_wre = 1'b0; ins_mem_rw = 1'b0; ins_data = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        check_state(102, 32'h4, IrJ, 32'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
